commit_stage: RTL and testbench

- Retire stage directly downstream of the reorder buffer.
- Consumes the registered commit bus: validCommit, result, destCommit, commitInfo, controlFlow, targetAddress, oldPC, previousIndex, statusSnap, commitRob.
- Drives architectural register-file writes, branch-predictor (BTB/gshare) updates and misprediction recovery (cpuReset/priorCommit/reset_ptr, fetch redirect, status-table restore).
- Drains committed stores to data memory through an in-order store-retire queue.

---
 rtl/commit_pkg.sv | 40 ++++
 rtl/commit_stage_store_retire_queue.sv | 81 ++++++++
 rtl/commit_stage.sv | 266 ++++++++++++++++++++++++++
 tb/tb_commit_stage.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_pkg.sv
// -----------------------------------------------------------------------------
// commit_pkg
// Shared types for the commit (retire) stage:
//   - commitInfo bit positions {regWrite, memWrite, jump, branch}
//   - control_flow_t : decoded controlFlow bus
//                      {isControl, nextState[1:0], writeBTB, takenBranch, reset}
//   - commit_state_e : recovery FSM states
//   - stq_entry_t    : one store-retire queue entry {addr, data}
// No ports (package).
// -----------------------------------------------------------------------------
package commit_pkg;

    localparam int XLEN = 32;

    // commitInfo bit positions
    localparam int REGWRITE = 3;
    localparam int MEMWRITE = 2;
    localparam int JUMP     = 1;
    localparam int BRANCH   = 0;

    typedef struct packed {
        logic       is_control;
        logic [1:0] next_state;
        logic       write_btb;
        logic       taken_branch;
        logic       reset;
    } control_flow_t;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_RECOVER = 2'd1,
        ST_WAIT    = 2'd2
    } commit_state_e;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
    } stq_entry_t;

endpackage

// File: rtl/commit_stage_store_retire_queue.sv
// -----------------------------------------------------------------------------
// store_retire_queue
// In-order FIFO of committed stores, drained to data memory one at a time.
// The head entry is presented with o_req high and holds stable until a cycle
// with i_ack, which pops it. o_hold rises one entry before full so the ROB,
// which reacts one edge later, can never overflow the queue.
//
// Ports:
//   clk           in   clock
//   i_rst         in   synchronous active-high reset (drops queued stores)
//   i_push        in   append i_push_entry at the tail
//   i_push_entry  in   store {addr, data}
//   i_ack         in   memory accepted the head this cycle
//   o_req         out  queue non-empty, head valid
//   o_head        out  head entry (zero when empty)
//   o_hold        out  count >= DEPTH-1
// -----------------------------------------------------------------------------
module store_retire_queue
    import commit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       i_rst,
    input  logic       i_push,
    input  stq_entry_t i_push_entry,
    input  logic       i_ack,
    output logic       o_req,
    output stq_entry_t o_head,
    output logic       o_hold
);

    localparam int          PW      = $clog2(DEPTH);
    localparam logic [PW:0] LP_FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0] LP_HOLD = (PW+1)'(DEPTH - 1);

    stq_entry_t    r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW:0]   r_count;
    logic          w_pop;
    logic          w_push;

    assign w_pop  = i_ack & (r_count != '0);
    // A push into a full queue is only accepted if the head leaves on the same edge.
    assign w_push = i_push & ((r_count != LP_FULL) | w_pop);

    // NOTE: the storage array is deliberately not reset; r_count alone says which slots are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= i_push_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            assert (!(i_push && !w_push));
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (PW+1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (PW+1)'(1);
            end
        end
    end

    assign o_req  = (r_count != '0);
    assign o_head = o_req ? r_mem[r_head] : '0;
    assign o_hold = (r_count >= LP_HOLD);

endmodule

// File: rtl/commit_stage.sv
// -----------------------------------------------------------------------------
// commit_stage
// Retire stage behind the reorder buffer. Turns each accepted commit into
// one-cycle registered effects: register-file write, BTB/gshare update and,
// for a mispredicted control instruction, a recovery pulse (ROB reset, fetch
// redirect, status restore). Stores drain through store_retire_queue.
// After a recovery the stage ignores commits for 1 + FLUSH_CYCLES edges
// (RECOVER then WAIT); queued stores are older and keep draining.
//
// Optional feature macro: COMMIT_STATS_EN adds o_instret / o_mispredicts.
//
// Ports:
//   clk, i_globalReset                 clock, synchronous active-high reset
//   i_validCommit .. i_commitRob       registered commit bus from the ROB
//   i_memAck                           memory accepted current store
//   o_commitHold                       combinational; ROB must not commit
//   o_rf*                              register-file write + ROB tag
//   o_btb*, o_pht*                     predictor updates
//   o_cpuReset, o_priorCommit,
//   o_reset_ptr                        recovery pulse to the ROB
//   o_redirectValid/PC                 fetch redirect
//   o_restoreValid/Status              register-status restore
//   o_memReq/Addr/Data                 store drain request
//   o_instret, o_mispredicts           (COMMIT_STATS_EN only) counters
// -----------------------------------------------------------------------------
module commit_stage
    import commit_pkg::*;
#(
    parameter int WIDTH        = 31,
    parameter int CONTROL      = 5,
    parameter int INDEX        = 7,
    parameter int ROB          = 2,
    parameter int STQ_DEPTH    = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             i_globalReset,
    input  logic             i_validCommit,
    input  logic [WIDTH:0]   i_result,
    input  logic [WIDTH:0]   i_destCommit,
    input  logic [3:0]       i_commitInfo,
    input  logic [CONTROL:0] i_controlFlow,
    input  logic [WIDTH:0]   i_targetAddress,
    input  logic [WIDTH:0]   i_oldPC,
    input  logic [INDEX:0]   i_previousIndex,
    input  logic [WIDTH:0]   i_statusSnap,
    input  logic [ROB:0]     i_commitRob,
    input  logic             i_memAck,
    output logic             o_commitHold,
    output logic             o_rfWrite,
    output logic [4:0]       o_rfAddr,
    output logic [WIDTH:0]   o_rfData,
    output logic [ROB:0]     o_rfRob,
    output logic             o_btbWrite,
    output logic [WIDTH:0]   o_btbPC,
    output logic [WIDTH:0]   o_btbTarget,
    output logic             o_phtWrite,
    output logic [INDEX:0]   o_phtIndex,
    output logic             o_phtTaken,
    output logic [1:0]       o_phtState,
    output logic             o_cpuReset,
    output logic             o_priorCommit,
    output logic [ROB:0]     o_reset_ptr,
    output logic             o_redirectValid,
    output logic [WIDTH:0]   o_redirectPC,
    output logic             o_restoreValid,
    output logic [WIDTH:0]   o_restoreStatus,
    output logic             o_memReq,
    output logic [WIDTH:0]   o_memAddr,
    output logic [WIDTH:0]   o_memData
`ifdef COMMIT_STATS_EN
    ,
    output logic [63:0]      o_instret,
    output logic [31:0]      o_mispredicts
`endif
);

    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    control_flow_t w_cf;
    commit_state_e r_state;
    commit_state_e w_state_next;
    logic [FW-1:0] r_flush_cnt;

    logic w_accept;
    logic w_rf_write;
    logic w_push;
    logic w_btb_write;
    logic w_pht_write;
    logic w_recover;
    logic w_unused;

    stq_entry_t w_push_entry;
    stq_entry_t w_mem_head;
    logic       w_mem_req;

    logic             r_rf_write;
    logic [4:0]       r_rf_addr;
    logic [WIDTH:0]   r_rf_data;
    logic [ROB:0]     r_rf_rob;
    logic             r_btb_write;
    logic [WIDTH:0]   r_btb_pc;
    logic [WIDTH:0]   r_btb_target;
    logic             r_pht_write;
    logic [INDEX:0]   r_pht_index;
    logic             r_pht_taken;
    logic [1:0]       r_pht_state;
    logic             r_recover;
    logic [ROB:0]     r_reset_ptr;
    logic [WIDTH:0]   r_redirect_pc;
    logic [WIDTH:0]   r_restore_status;

    assign w_cf = control_flow_t'(i_controlFlow);

    // -------------------------------------------------------------------------
    // Recovery FSM: next state and commit acceptance
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        w_state_next = r_state;
        w_accept     = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                w_accept = i_validCommit;
                if (i_validCommit && w_cf.reset) begin
                    w_state_next = ST_RECOVER;
                end
            end
            ST_RECOVER: w_state_next = ST_WAIT;
            ST_WAIT: begin
                if (r_flush_cnt == '0) begin
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_globalReset) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            // WAIT lasts FLUSH_CYCLES cycles: load on leaving RECOVER, count down to 0.
            if (r_state == ST_RECOVER) begin
                r_flush_cnt <= FW'(FLUSH_CYCLES - 1);
            end else if (r_state == ST_WAIT && r_flush_cnt != '0) begin
                r_flush_cnt <= r_flush_cnt - FW'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Effects of an accepted commit
    // -------------------------------------------------------------------------
    assign w_rf_write  = w_accept & i_commitInfo[REGWRITE] & (i_destCommit[4:0] != 5'd0);
    assign w_push      = w_accept & i_commitInfo[MEMWRITE];
    assign w_btb_write = w_accept & w_cf.is_control & w_cf.write_btb;
    assign w_pht_write = w_accept & w_cf.is_control & i_commitInfo[BRANCH];
    assign w_recover   = w_accept & w_cf.reset;
    // The jump flag carries no retire-side effect.
    assign w_unused    = i_commitInfo[JUMP];

    // Payload fields are zeroed when their strobe is low so idle outputs read 0.
    always_ff @(posedge clk) begin
        if (i_globalReset) begin
            r_rf_write       <= 1'b0;
            r_rf_addr        <= '0;
            r_rf_data        <= '0;
            r_rf_rob         <= '0;
            r_btb_write      <= 1'b0;
            r_btb_pc         <= '0;
            r_btb_target     <= '0;
            r_pht_write      <= 1'b0;
            r_pht_index      <= '0;
            r_pht_taken      <= 1'b0;
            r_pht_state      <= '0;
            r_recover        <= 1'b0;
            r_reset_ptr      <= '0;
            r_redirect_pc    <= '0;
            r_restore_status <= '0;
        end else begin
            r_rf_write       <= w_rf_write;
            r_rf_addr        <= w_rf_write  ? i_destCommit[4:0] : '0;
            r_rf_data        <= w_rf_write  ? i_result          : '0;
            r_rf_rob         <= w_rf_write  ? i_commitRob       : '0;
            r_btb_write      <= w_btb_write;
            r_btb_pc         <= w_btb_write ? i_oldPC           : '0;
            r_btb_target     <= w_btb_write ? i_targetAddress   : '0;
            r_pht_write      <= w_pht_write;
            r_pht_index      <= w_pht_write ? i_previousIndex   : '0;
            r_pht_taken      <= w_pht_write & w_cf.taken_branch;
            r_pht_state      <= w_pht_write ? w_cf.next_state   : '0;
            r_recover        <= w_recover;
            r_reset_ptr      <= w_recover   ? i_commitRob       : '0;
            r_redirect_pc    <= w_recover   ? i_targetAddress   : '0;
            r_restore_status <= w_recover   ? i_statusSnap      : '0;
        end
    end

    assign o_rfWrite       = r_rf_write;
    assign o_rfAddr        = r_rf_addr;
    assign o_rfData        = r_rf_data;
    assign o_rfRob         = r_rf_rob;
    assign o_btbWrite      = r_btb_write;
    assign o_btbPC         = r_btb_pc;
    assign o_btbTarget     = r_btb_target;
    assign o_phtWrite      = r_pht_write;
    assign o_phtIndex      = r_pht_index;
    assign o_phtTaken      = r_pht_taken;
    assign o_phtState      = r_pht_state;
    assign o_cpuReset      = r_recover;
    assign o_priorCommit   = r_recover;
    assign o_reset_ptr     = r_reset_ptr;
    assign o_redirectValid = r_recover;
    assign o_redirectPC    = r_redirect_pc;
    assign o_restoreValid  = r_recover;
    assign o_restoreStatus = r_restore_status;

    // -------------------------------------------------------------------------
    // Store drain
    // -------------------------------------------------------------------------
    assign w_push_entry.addr = i_destCommit;
    assign w_push_entry.data = i_result;

    store_retire_queue #(
        .DEPTH        (STQ_DEPTH)
    ) u_stq (
        .clk          (clk),
        .i_rst        (i_globalReset),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_ack        (i_memAck),
        .o_req        (w_mem_req),
        .o_head       (w_mem_head),
        .o_hold       (o_commitHold)
    );

    assign o_memReq  = w_mem_req;
    assign o_memAddr = w_mem_head.addr;
    assign o_memData = w_mem_head.data;

`ifdef COMMIT_STATS_EN
    logic [63:0] r_instret;
    logic [31:0] r_mispredicts;

    always_ff @(posedge clk) begin
        if (i_globalReset) begin
            r_instret     <= '0;
            r_mispredicts <= '0;
        end else begin
            if (w_accept) begin
                r_instret <= r_instret + 64'd1;
            end
            if (w_recover) begin
                r_mispredicts <= r_mispredicts + 32'd1;
            end
        end
    end

    assign o_instret     = r_instret;
    assign o_mispredicts = r_mispredicts;
`endif

endmodule

// File: tb/tb_commit_stage.sv
// -----------------------------------------------------------------------------
// tb_commit_stage
// Scoreboard bench for commit_stage. The stimulus task computes, from the
// commit-bus rules, which effects each commit must produce and in which cycle,
// and queues them; a negedge monitor pops and compares against the outputs.
// Store ordering, count and hold are modelled with a queue and an integer.
// -----------------------------------------------------------------------------
module tb_commit_stage;

    localparam int DEPTH = 4;
    localparam int FLUSH = 2;

    logic        clk = 1'b0;
    logic        globalReset, validCommit, memAck;
    logic [31:0] result, destCommit, targetAddress, oldPC, statusSnap;
    logic [3:0]  commitInfo;
    logic [5:0]  controlFlow;
    logic [7:0]  previousIndex;
    logic [2:0]  commitRob;

    logic        commitHold, rfWrite, btbWrite, phtWrite, phtTaken;
    logic        cpuReset, priorCommit, redirectValid, restoreValid, memReq;
    logic [4:0]  rfAddr;
    logic [31:0] rfData, btbPC, btbTarget, redirectPC, restoreStatus, memAddr, memData;
    logic [2:0]  rfRob, reset_ptr;
    logic [7:0]  phtIndex;
    logic [1:0]  phtState;
`ifdef COMMIT_STATS_EN
    logic [63:0] instret;
    logic [31:0] mispredicts;
`endif

    always #5 clk = ~clk;

    commit_stage #(
        .STQ_DEPTH       (DEPTH),
        .FLUSH_CYCLES    (FLUSH)
    ) dut (
        .clk             (clk),
        .i_globalReset   (globalReset),
        .i_validCommit   (validCommit),
        .i_result        (result),
        .i_destCommit    (destCommit),
        .i_commitInfo    (commitInfo),
        .i_controlFlow   (controlFlow),
        .i_targetAddress (targetAddress),
        .i_oldPC         (oldPC),
        .i_previousIndex (previousIndex),
        .i_statusSnap    (statusSnap),
        .i_commitRob     (commitRob),
        .i_memAck        (memAck),
        .o_commitHold    (commitHold),
        .o_rfWrite       (rfWrite),
        .o_rfAddr        (rfAddr),
        .o_rfData        (rfData),
        .o_rfRob         (rfRob),
        .o_btbWrite      (btbWrite),
        .o_btbPC         (btbPC),
        .o_btbTarget     (btbTarget),
        .o_phtWrite      (phtWrite),
        .o_phtIndex      (phtIndex),
        .o_phtTaken      (phtTaken),
        .o_phtState      (phtState),
        .o_cpuReset      (cpuReset),
        .o_priorCommit   (priorCommit),
        .o_reset_ptr     (reset_ptr),
        .o_redirectValid (redirectValid),
        .o_redirectPC    (redirectPC),
        .o_restoreValid  (restoreValid),
        .o_restoreStatus (restoreStatus),
        .o_memReq        (memReq),
        .o_memAddr       (memAddr),
        .o_memData       (memData)
`ifdef COMMIT_STATS_EN
        ,
        .o_instret       (instret),
        .o_mispredicts   (mispredicts)
`endif
    );

    // Expected effects, stamped with the cycle in which they must be visible.
    typedef struct { int cyc; logic [4:0] addr; logic [31:0] data; logic [2:0] rob; } rf_exp_t;
    typedef struct { int cyc; logic [31:0] pc; logic [31:0] tgt; } btb_exp_t;
    typedef struct { int cyc; logic [7:0] idx; logic taken; logic [1:0] st; } pht_exp_t;
    typedef struct { int cyc; logic [2:0] rob; logic [31:0] pc; logic [31:0] status; } rec_exp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } st_exp_t;

    rf_exp_t  rf_q[$];
    btb_exp_t btb_q[$];
    pht_exp_t pht_q[$];
    rec_exp_t rec_q[$];
    st_exp_t  st_q[$];

    int     cyc = 0;
    int     n_tests = 0;
    int     n_fail = 0;
    int     model_cnt = 0;      // stores held by the DUT queue after the latest edge
    int     ignore_until = 0;   // last edge whose commit is discarded after a recovery
    longint m_instret = 0;
    int     m_mispred = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One commit-bus cycle. Expectations for the edge that samples these inputs
    // are queued first; the store count is advanced once that edge has passed.
    task automatic drive(input logic v, input logic [31:0] dest, input logic [31:0] res,
                         input logic [3:0] info, input logic [5:0] cf, input logic [31:0] tgt,
                         input logic [31:0] pc, input logic [7:0] pidx, input logic [31:0] snap,
                         input logic [2:0] rob, input logic ack, input logic rst);
        int   e;
        int   pushed;
        int   popped;
        logic acc;
        if (model_cnt >= DEPTH - 1) v = 1'b0;   // the ROB honours commitHold
        globalReset   = rst;
        validCommit   = v;
        destCommit    = dest;
        result        = res;
        commitInfo    = info;
        controlFlow   = cf;
        targetAddress = tgt;
        oldPC         = pc;
        previousIndex = pidx;
        statusSnap    = snap;
        commitRob     = rob;
        memAck        = ack;
        e      = cyc + 1;
        acc    = v && !rst && (e > ignore_until);
        pushed = 0;
        if (acc) begin
            m_instret++;
            if (info[3] && dest[4:0] != 5'd0) rf_q.push_back('{e, dest[4:0], res, rob});
            if (info[2]) begin
                st_q.push_back('{dest, res});
                pushed = 1;
            end
            if (cf[5]) begin
                if (cf[2]) btb_q.push_back('{e, pc, tgt});
                if (info[0]) pht_q.push_back('{e, pidx, cf[1], cf[4:3]});
            end
            if (cf[0]) begin
                rec_q.push_back('{e, rob, tgt, snap});
                ignore_until = e + 1 + FLUSH;
                m_mispred++;
            end
        end
        popped = (ack && model_cnt > 0) ? 1 : 0;
        @(posedge clk);
        #1;
        if (rst) begin
            rf_q.delete(); btb_q.delete(); pht_q.delete(); rec_q.delete(); st_q.delete();
            model_cnt    = 0;
            ignore_until = e;
            m_instret    = 0;
            m_mispred    = 0;
        end else begin
            model_cnt = model_cnt + pushed - popped;
        end
    endtask

    task automatic idle(input logic ack, input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 4'h0, 6'h00, 0, 0, 8'h00, 0, 3'd0, ack, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_strobes"}, {commitHold, rfWrite, btbWrite, phtWrite, phtTaken, cpuReset,
                                  priorCommit, redirectValid, restoreValid, memReq}, 64'd0);
        check({tag, "_rf"}, {rfAddr, rfData, rfRob}, 64'd0);
        check({tag, "_btb"}, {btbPC, btbTarget}, 64'd0);
        check({tag, "_pht"}, {phtIndex, phtState}, 64'd0);
        check({tag, "_recovery"}, {reset_ptr, redirectPC}, 64'd0);
        check({tag, "_status"}, restoreStatus, 64'd0);
        check({tag, "_mem"}, {memAddr, memData}, 64'd0);
`ifdef COMMIT_STATS_EN
        check({tag, "_instret"}, instret, 64'd0);
        check({tag, "_mispredicts"}, mispredicts, 64'd0);
`endif
    endtask

    // Monitor: every cycle compares each output channel with the scoreboard.
    always @(negedge clk) begin
        rf_exp_t  r;
        btb_exp_t b;
        pht_exp_t p;
        rec_exp_t c;
        st_exp_t  s;
        logic     due;

        due = (rf_q.size() > 0) && (rf_q[0].cyc == cyc);
        check("rfWrite", rfWrite, due);
        if (due) begin
            r = rf_q.pop_front();
            check("rfAddr", rfAddr, r.addr);
            check("rfData", rfData, r.data);
            check("rfRob", rfRob, r.rob);
        end

        due = (btb_q.size() > 0) && (btb_q[0].cyc == cyc);
        check("btbWrite", btbWrite, due);
        if (due) begin
            b = btb_q.pop_front();
            check("btbPC", btbPC, b.pc);
            check("btbTarget", btbTarget, b.tgt);
        end

        due = (pht_q.size() > 0) && (pht_q[0].cyc == cyc);
        check("phtWrite", phtWrite, due);
        if (due) begin
            p = pht_q.pop_front();
            check("phtIndex", phtIndex, p.idx);
            check("phtTaken", phtTaken, p.taken);
            check("phtState", phtState, p.st);
        end

        due = (rec_q.size() > 0) && (rec_q[0].cyc == cyc);
        check("recovery_strobes", {cpuReset, priorCommit, redirectValid, restoreValid}, {4{due}});
        if (due) begin
            c = rec_q.pop_front();
            check("reset_ptr", reset_ptr, c.rob);
            check("redirectPC", redirectPC, c.pc);
            check("restoreStatus", restoreStatus, c.status);
        end

        check("commitHold", commitHold, model_cnt >= DEPTH - 1);
        check("memReq", memReq, model_cnt > 0);
        if (memReq && st_q.size() > 0) begin
            check("memAddr", memAddr, st_q[0].addr);
            check("memData", memData, st_q[0].data);
            if (memAck) s = st_q.pop_front();
        end
    end

    initial begin
        // Reset
        drive(1'b0, 0, 0, 4'h0, 6'h00, 0, 0, 8'h00, 0, 3'd0, 1'b0, 1'b1);
        drive(1'b0, 0, 0, 4'h0, 6'h00, 0, 0, 8'h00, 0, 3'd0, 1'b0, 1'b1);
        check_all_zero("reset");
        idle(1'b0, 2);

        // Register writes: dest 5 writes, dest 0 does not
        drive(1'b1, 32'd5, 32'hDEAD_BEEF, 4'b1000, 6'h00, 0, 0, 8'h00, 0, 3'd3, 1'b0, 1'b0);
        drive(1'b1, 32'd0, 32'hDEAD_BEEF, 4'b1000, 6'h00, 0, 0, 8'h00, 0, 3'd3, 1'b0, 1'b0);
        idle(1'b0, 2);

        // Three stores with memAck low, then one ack per cycle
        drive(1'b1, 32'h100, 32'h1111_0000, 4'b0100, 6'h00, 0, 0, 8'h00, 0, 3'd0, 1'b0, 1'b0);
        drive(1'b1, 32'h104, 32'h2222_0000, 4'b0100, 6'h00, 0, 0, 8'h00, 0, 3'd1, 1'b0, 1'b0);
        drive(1'b1, 32'h108, 32'h3333_0000, 4'b0100, 6'h00, 0, 0, 8'h00, 0, 3'd2, 1'b0, 1'b0);
        idle(1'b0, 2);
        idle(1'b1, 4);

        // Mispredicted branch: recovery pulse, then the next commits are dropped
        drive(1'b1, 0, 0, 4'b0001, 6'b1_00_0_0_1, 32'h40, 32'h10, 8'h11, 32'hA5, 3'd6, 1'b0, 1'b0);
        drive(1'b1, 32'd7, 32'h7777, 4'b1100, 6'h00, 0, 0, 8'h00, 0, 3'd7, 1'b0, 1'b0);
        drive(1'b1, 32'd8, 32'h8888, 4'b1100, 6'h00, 0, 0, 8'h00, 0, 3'd0, 1'b0, 1'b0);
        drive(1'b1, 32'd9, 32'h9999, 4'b1000, 6'h00, 0, 0, 8'h00, 0, 3'd1, 1'b0, 1'b0);
        drive(1'b1, 32'd10, 32'hAAAA, 4'b1000, 6'h00, 0, 0, 8'h00, 0, 3'd2, 1'b0, 1'b0);
        idle(1'b0, 2);

        // Taken branch with BTB write and gshare update
        drive(1'b1, 0, 0, 4'b0001, 6'b1_10_1_1_0, 32'h80, 32'h20, 8'h3C, 0, 3'd4, 1'b0, 1'b0);
        idle(1'b0, 2);

        // Reset while draining two stores
        drive(1'b1, 32'h200, 32'hCAFE_0001, 4'b0100, 6'h00, 0, 0, 8'h00, 0, 3'd0, 1'b0, 1'b0);
        drive(1'b1, 32'h204, 32'hCAFE_0002, 4'b0100, 6'h00, 0, 0, 8'h00, 0, 3'd1, 1'b0, 1'b0);
        idle(1'b0, 1);
        drive(1'b0, 0, 0, 4'h0, 6'h00, 0, 0, 8'h00, 0, 3'd0, 1'b0, 1'b1);
        check_all_zero("drain_reset");
        idle(1'b1, 3);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] dest;
            logic [5:0]  cf;
            logic        rst;
            dest = $urandom();
            if ($urandom_range(3) == 0) dest[4:0] = 5'd0;
            cf = 6'($urandom());
            cf[0] = ($urandom_range(9) == 0);
            rst = ($urandom_range(149) == 0);
            drive($urandom_range(3) != 0, dest, $urandom(), 4'($urandom()), cf, $urandom(),
                  $urandom(), 8'($urandom()), $urandom(), 3'($urandom()),
                  $urandom_range(1) == 1, rst);
            if (rst) check_all_zero("random_reset");
        end

        // Drain and confirm nothing expected was left unseen
        idle(1'b1, 10);
        check("leftover_expectations",
              64'(rf_q.size() + btb_q.size() + pht_q.size() + rec_q.size() + st_q.size()), 64'd0);
`ifdef COMMIT_STATS_EN
        check("instret", instret, 64'(m_instret));
        check("mispredicts", mispredicts, 64'(m_mispred));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
